// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: RESET#/CKE timing, MRS2/3/1/0 and optional ZQCL, then init_done.
// Define DDR3_INIT_ZQCL_EN to issue ZQCL after MR0; otherwise MR0 goes straight to DONE.
module ddr3_init_seq #(
  parameter int unsigned T_RESET_CYC  = 40000,
  parameter int unsigned T_CKE_CYC    = 100000,
  parameter int unsigned T_XPR_CYC    = 54,
  parameter int unsigned T_MRD_CYC    = 4,
  parameter int unsigned T_MOD_CYC    = 4,
  parameter int unsigned T_ZQINIT_CYC = 128,
  parameter logic [15:0] MR0          = 16'h0B30,
  parameter logic [15:0] MR1          = 16'h0044,
  parameter logic [15:0] MR2          = 16'h0008,
  parameter logic [15:0] MR3          = 16'h0000
) (
  input  logic        divclk,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic        cmd_ready,
  output logic        ddr_reset_n,
  output logic        ddr_cke,
  output logic        cmd_valid,
  output logic [3:0]  cmd,
  output logic [2:0]  ba,
  output logic [15:0] addr,
  output logic        init_done
);

  // state     | meaning
  // WAIT_LOCK | idle, all outputs at reset values until pll_locked
  // RST_HOLD  | RESET# low for T_RESET_CYC
  // CKE_WAIT  | RESET# high, CKE low for T_CKE_CYC
  // XPR       | CKE high, wait T_XPR_CYC before the first MRS
  // MRS2..0   | issue MRn (one set-up cycle, handshake, then tMRD/tMOD gap)
  // ZQCL      | issue ZQCL, then wait T_ZQINIT_CYC
  // DONE      | init_done held high
  typedef enum logic [3:0] {
    WAIT_LOCK, RST_HOLD, CKE_WAIT, XPR, MRS2, MRS3, MRS1, MRS0, ZQCL, DONE
  } state_t;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  // Terminal count of an up-counter started at zero; a zero delay behaves as one cycle.
  function automatic logic [19:0] tc_of(input int unsigned t);
    return (t == 0) ? 20'd0 : 20'(t - 1);
  endfunction

  localparam logic [19:0] TC_RESET = tc_of(T_RESET_CYC);
  localparam logic [19:0] TC_CKE   = tc_of(T_CKE_CYC);
  localparam logic [19:0] TC_XPR   = tc_of(T_XPR_CYC);
  localparam logic [19:0] TC_MRD   = tc_of(T_MRD_CYC);
  localparam logic [19:0] TC_MOD   = tc_of(T_MOD_CYC);
  localparam logic [19:0] TC_ZQ    = tc_of(T_ZQINIT_CYC);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        sent_q, sent_d;
  logic        rstn_q, rstn_d;
  logic        cke_q, cke_d;
  logic        valid_q, valid_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [2:0]  ba_q, ba_d;
  logic [15:0] addr_q, addr_d;
  logic        done_q, done_d;

  logic [3:0]  cmd_sel;
  logic [2:0]  ba_sel;
  logic [15:0] addr_sel;
  logic [19:0] gap_tc;
  state_t      nxt_state;
  logic        is_cmd_state;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sent_d    = sent_q;
    rstn_d    = rstn_q;
    cke_d     = cke_q;
    valid_d   = valid_q;
    cmd_d     = cmd_q;
    ba_d      = ba_q;
    addr_d    = addr_q;
    done_d    = done_q;
    cmd_sel   = CMD_MRS;
    ba_sel    = 3'd0;
    addr_sel  = 16'h0000;
    gap_tc    = TC_MRD;
    nxt_state = DONE;
    is_cmd_state = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (pll_locked) begin
          state_d = RST_HOLD;
          cnt_d   = '0;
        end
      end
      RST_HOLD: begin
        if (cnt_q == TC_RESET) begin
          rstn_d  = 1'b1;
          state_d = CKE_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      CKE_WAIT: begin
        if (cnt_q == TC_CKE) begin
          cke_d   = 1'b1;
          state_d = XPR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      XPR: begin
        if (cnt_q == TC_XPR) begin
          state_d = MRS2;
          sent_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      MRS2: begin
        is_cmd_state = 1'b1;
        ba_sel    = 3'd2;
        addr_sel  = MR2;
        nxt_state = MRS3;
      end
      MRS3: begin
        is_cmd_state = 1'b1;
        ba_sel    = 3'd3;
        addr_sel  = MR3;
        nxt_state = MRS1;
      end
      MRS1: begin
        is_cmd_state = 1'b1;
        ba_sel    = 3'd1;
        addr_sel  = MR1;
        nxt_state = MRS0;
      end
      MRS0: begin
        is_cmd_state = 1'b1;
        ba_sel    = 3'd0;
        addr_sel  = MR0;
        gap_tc    = TC_MOD;
`ifdef DDR3_INIT_ZQCL_EN
        nxt_state = ZQCL;
`else
        nxt_state = DONE;
`endif
      end
      ZQCL: begin
        is_cmd_state = 1'b1;
        cmd_sel   = CMD_ZQCL;
        addr_sel  = 16'h0400;
        gap_tc    = TC_ZQ;
        nxt_state = DONE;
      end
      DONE: begin
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Command states: present payload, hold it until accepted, then count the gap.
    if (is_cmd_state) begin
      if (!sent_q) begin
        if (!valid_q) begin
          valid_d = 1'b1;
          cmd_d   = cmd_sel;
          ba_d    = ba_sel;
          addr_d  = addr_sel;
        end else if (cmd_ready) begin
          valid_d = 1'b0;
          cmd_d   = CMD_NOP;
          ba_d    = 3'd0;
          addr_d  = 16'h0000;
          sent_d  = 1'b1;
          cnt_d   = '0;
        end
      end else if (cnt_q == gap_tc) begin
        state_d = nxt_state;
        sent_d  = 1'b0;
        cnt_d   = '0;
        done_d  = (nxt_state == DONE);
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end

    // Losing lock anywhere past WAIT_LOCK restarts the whole sequence.
    if (state_q != WAIT_LOCK && !pll_locked) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      sent_d  = 1'b0;
      rstn_d  = 1'b0;
      cke_d   = 1'b0;
      valid_d = 1'b0;
      cmd_d   = CMD_NOP;
      ba_d    = 3'd0;
      addr_d  = 16'h0000;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge divclk) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      sent_q  <= 1'b0;
      rstn_q  <= 1'b0;
      cke_q   <= 1'b0;
      valid_q <= 1'b0;
      cmd_q   <= CMD_NOP;
      ba_q    <= 3'd0;
      addr_q  <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      rstn_q  <= rstn_d;
      cke_q   <= cke_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign ddr_reset_n = rstn_q;
  assign ddr_cke     = cke_q;
  assign cmd_valid   = valid_q;
  assign cmd         = cmd_q;
  assign ba          = ba_q;
  assign addr        = addr_q;
  assign init_done   = done_q;

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Bench for ddr3_init_seq: random cmd_ready/lock/reset stimulus against a cycle-timeline model.
module tb_ddr3_init_seq;

  localparam int TR = 20;
  localparam int TC = 50;
  localparam int TX = 5;
  localparam int TMRD = 4;
  localparam int TMOD = 4;
  localparam int TZQ = 16;
`ifdef DDR3_INIT_ZQCL_EN
  localparam int NX = 5;
  localparam int LAST_GAP = TZQ;
`else
  localparam int NX = 4;
  localparam int LAST_GAP = TMOD;
`endif

  logic        divclk = 1'b0;
  logic        reset = 1'b1;
  logic        pll_locked = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        ddr_reset_n, ddr_cke, cmd_valid, init_done;
  logic [3:0]  cmd;
  logic [2:0]  ba;
  logic [15:0] addr;

  ddr3_init_seq #(
    .T_RESET_CYC(TR), .T_CKE_CYC(TC), .T_XPR_CYC(TX),
    .T_MRD_CYC(TMRD), .T_MOD_CYC(TMOD), .T_ZQINIT_CYC(TZQ)
  ) dut (
    .divclk(divclk), .reset(reset), .pll_locked(pll_locked), .cmd_ready(cmd_ready),
    .ddr_reset_n(ddr_reset_n), .ddr_cke(ddr_cke), .cmd_valid(cmd_valid),
    .cmd(cmd), .ba(ba), .addr(addr), .init_done(init_done)
  );

  always #5 divclk = ~divclk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Model: lock cycle, commands accepted so far, when the next command appears, when done rises.
  int n = 0;
  int lock_at = -1;
  int k = 0;
  int issue_at = 0;
  int done_at = -1;

  int rstn_rise = -1, cke_rise = -1, first_valid = -1, done_rise = -1, last_xfer = -1;
  int xfers = 0, mrs3_hold = 0;
  logic [2:0]  first_ba;
  logic [15:0] first_addr;
  bit rstn_p = 0, cke_p = 0, valid_p = 0, done_p = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  function automatic bit model_valid(input int c);
    return lock_at >= 0 && k < NX && c >= issue_at;
  endfunction

  function automatic logic [2:0] exp_ba(input int i);
    case (i)
      0: return 3'd2;
      1: return 3'd3;
      2: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [15:0] exp_addr(input int i);
    case (i)
      0: return 16'h0008;
      1: return 16'h0000;
      2: return 16'h0044;
      3: return 16'h0B30;
      default: return 16'h0400;
    endcase
  endfunction

  function automatic int gap_of(input int i);
    return (i < 3) ? TMRD : (i == 3) ? TMOD : TZQ;
  endfunction

  task automatic tick(input bit r, input bit lk, input bit rd);
    bit ev;
    bit locked;
    int g;
    @(negedge divclk);
    n++;
    if (chk_en) begin
      ev = model_valid(n);
      locked = lock_at >= 0;
      chk("rstn", 32'(ddr_reset_n), 32'(locked && n >= lock_at + TR + 1));
      chk("cke", 32'(ddr_cke), 32'(locked && n >= lock_at + TR + TC + 1));
      chk("done", 32'(init_done), 32'(locked && done_at >= 0 && n >= done_at));
      chk("valid", 32'(cmd_valid), 32'(ev));
      chk("cmd", 32'(cmd), ev ? ((k < 4) ? 32'h0 : 32'h6) : 32'h7);
      chk("ba", 32'(ba), ev ? 32'(exp_ba(k)) : 32'h0);
      chk("addr", 32'(addr), ev ? 32'(exp_addr(k)) : 32'h0);
    end
    if (ddr_reset_n && !rstn_p) rstn_rise = n;
    if (ddr_cke && !cke_p) cke_rise = n;
    if (init_done && !done_p) done_rise = n;
    if (cmd_valid && !valid_p && first_valid < 0) begin
      first_valid = n;
      first_ba = ba;
      first_addr = addr;
    end
    if (cmd_valid && ba == 3'd3 && cmd == 4'b0000 && addr == 16'h0000) mrs3_hold++;
    if (cmd_valid && rd && !r && lk) begin
      xfers++;
      last_xfer = n;
    end
    rstn_p = ddr_reset_n; cke_p = ddr_cke; valid_p = cmd_valid; done_p = init_done;
    reset = r;
    pll_locked = lk;
    cmd_ready = rd;
    if (r) begin
      lock_at = -1; k = 0; done_at = -1;
    end else if (lock_at < 0) begin
      if (lk) begin
        lock_at = n; k = 0; done_at = -1; xfers = 0;
        issue_at = n + TR + TC + TX + 2;
      end
    end else if (!lk) begin
      lock_at = -1; k = 0; done_at = -1;
    end else if (model_valid(n) && rd) begin
      g = gap_of(k);
      k++;
      if (k == NX) done_at = n + g + 1;
      else issue_at = n + g + 2;
    end
  endtask

  task automatic run_to_done(input int mode, input int budget);
    int stall = 0;
    int it = 0;
    bit rd;
    while (!(lock_at >= 0 && done_at >= 0 && n >= done_at + 2) && it < budget) begin
      if (mode == 0) rd = 1'b1;
      else if (k == 1 && model_valid(n + 1) && stall < 10) begin
        rd = 1'b0;
        stall++;
      end else rd = 1'($urandom_range(0, 1));
      tick(1'b0, 1'b1, rd);
      it++;
    end
    if (it >= budget) chk("timeout", 32'd0, 32'd1);
    chk("xfer_cnt", 32'(xfers), 32'(NX));
  endtask

  task automatic run_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int l0, it, d;
    tick(1'b1, 1'b0, 1'b0);
    chk_en = 1;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Baseline: lock at cycle 0, cmd_ready always high.
    first_valid = -1;
    l0 = n + 1;
    run_to_done(0, 2000);
    chk("rstn_rise", 32'(rstn_rise - l0), 32'd21);
    chk("cke_rise", 32'(cke_rise - l0), 32'd71);
    chk("first_mrs", 32'(first_valid - l0), 32'd77);
    chk("first_ba", 32'(first_ba), 32'd2);
    chk("first_addr", 32'(first_addr), 32'h0008);
    chk("done_gap", 32'(done_rise - last_xfer), 32'(LAST_GAP + 1));

    // Reset while in DONE, then random stalls with a 10-cycle stall on MRS3.
    tick(1'b1, 1'b1, 1'b1);
    mrs3_hold = 0;
    run_to_done(1, 3000);
    chk("mrs3_hold", 32'(mrs3_hold >= 11), 32'd1);
    chk("done_gap2", 32'(done_rise - last_xfer), 32'(LAST_GAP + 1));

    // Lock lost during CKE_WAIT for 3 cycles, then full restart.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    d = $urandom_range(1, 38);
    run_cycles(TR + d);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    run_to_done(1, 3000);

    // Reset mid-handshake of MRS1 with cmd_ready asserted.
    tick(1'b1, 1'b0, 1'b0);
    it = 0;
    while (!(k == 2 && model_valid(n + 1)) && it < 500) begin
      tick(1'b0, 1'b1, 1'b1);
      it++;
    end
    if (it >= 500) chk("mrs1_timeout", 32'd0, 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    run_to_done(0, 2000);

    // Random lock drops at arbitrary points.
    for (int r = 0; r < 4; r++) begin
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b1);
      run_cycles($urandom_range(1, 150));
      d = $urandom_range(1, 3);
      for (int i = 0; i < d; i++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      run_to_done(1, 3000);
    end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_init_seq.md
DDR3_INIT_SEQ -- requirements
Module: ddr3_init_seq

Interface
REQ-001 SHALL have parameter T_RESET_CYC, default 40000, divclk cycles ddr_reset_n held low after lock (200 us).
REQ-002 SHALL have parameter T_CKE_CYC, default 100000, cycles from ddr_reset_n high to ddr_cke high (500 us).
REQ-003 SHALL have parameter T_XPR_CYC, default 54, cycles from ddr_cke high to first MRS.
REQ-004 SHALL have parameters T_MRD_CYC=4, T_MOD_CYC=4, T_ZQINIT_CYC=128, the post-command gaps.
REQ-005 SHALL have parameters MR0=16'h0B30, MR1=16'h0044, MR2=16'h0008, MR3=16'h0000, the mode-register payloads.
REQ-006 divclk  input  1  sole clock, the divided SERDES clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pll_locked  input  1  PLL lock indication, already synchronous to divclk.
REQ-009 cmd_ready  input  1  downstream command serializer accepts cmd this cycle.
REQ-010 ddr_reset_n  output  1  DRAM RESET#.
REQ-011 ddr_cke  output  1  DRAM CKE.
REQ-012 cmd_valid  output  1  command payload valid.
REQ-013 cmd  output  4  {cs_n, ras_n, cas_n, we_n}.
REQ-014 ba  output  3  bank address.
REQ-015 addr  output  16  row/MR address.
REQ-016 init_done  output  1  initialization complete.

Function
REQ-017 States SHALL be WAIT_LOCK, RST_HOLD, CKE_WAIT, XPR, MRS2, MRS3, MRS1, MRS0, ZQCL, DONE.
REQ-018 WAIT_LOCK -> RST_HOLD on first cycle pll_locked=1; counter loaded to zero.
REQ-019 RST_HOLD SHALL keep ddr_reset_n=0 for exactly T_RESET_CYC cycles, then drive ddr_reset_n=1 and enter CKE_WAIT.
REQ-020 CKE_WAIT SHALL last T_CKE_CYC cycles, then drive ddr_cke=1 and enter XPR; XPR SHALL last T_XPR_CYC cycles.
REQ-021 Each MRSn state SHALL assert cmd_valid with cmd=4'b0000, ba=n, addr=MRn until cmd_valid&&cmd_ready.
REQ-022 Payload SHALL be stable while cmd_valid=1 and cmd_ready=0; cmd_valid SHALL never deassert without a transfer except on abort (REQ-027).
REQ-023 After the transfer cycle, cmd_valid=0, cmd=4'b0111 (NOP), ba=0, addr=0, and the next state SHALL begin after T_MRD_CYC cycles (MRS2/3/1) or T_MOD_CYC cycles (MRS0).
REQ-024 Order SHALL be MRS2, MRS3, MRS1, MRS0, ZQCL, DONE.
REQ-025 ZQCL SHALL issue cmd=4'b0110, ba=0, addr=16'h0400 under the same handshake, then wait T_ZQINIT_CYC cycles before DONE.
REQ-026 DONE SHALL hold init_done=1, ddr_reset_n=1, ddr_cke=1, cmd=NOP, cmd_valid=0.
REQ-027 pll_locked=0 in any state other than WAIT_LOCK SHALL on the next edge return to WAIT_LOCK with all outputs at reset values (abort).
REQ-028 Delay counter SHALL be 20 bits; any timing parameter of 0 SHALL be treated as 1; parameters above 2^20-1 are illegal.
REQ-029 cmd_ready while cmd_valid=0 SHALL be ignored.

Reset
REQ-030 reset=1 SHALL on the next edge force WAIT_LOCK, counter=0, ddr_reset_n=0, ddr_cke=0, cmd_valid=0, cmd=4'b0111, ba=0, addr=0, init_done=0.
REQ-031 reset SHALL override pll_locked and cmd_ready, including mid-handshake and in DONE.

Configuration
REQ-032 Macro DDR3_INIT_ZQCL_EN SHALL, when defined, include the ZQCL state per REQ-025.
REQ-033 Without DDR3_INIT_ZQCL_EN, MRS0 SHALL proceed to DONE after T_MOD_CYC cycles and no ZQCL command SHALL be issued.

Verification (parameters T_RESET_CYC=20, T_CKE_CYC=50, T_XPR_CYC=5, T_MRD_CYC=4, T_MOD_CYC=4, T_ZQINIT_CYC=16)
REQ-034 reset pulse, pll_locked=1 at cycle 0, cmd_ready=1 -> ddr_reset_n rises at cycle 21, ddr_cke at 71, first MRS (ba=2, addr=16'h0008) at 77.
REQ-035 cmd_ready=0 for 10 cycles during MRS3 -> cmd_valid, cmd=4'b0000, ba=3, addr=16'h0000 held stable all 10 cycles; single transfer.
REQ-036 Full run with DDR3_INIT_ZQCL_EN -> exactly 5 transfers in order ba 2,3,1,0 then ZQCL addr=16'h0400; init_done 16 cycles after ZQCL transfer.
REQ-037 Full run without DDR3_INIT_ZQCL_EN -> exactly 4 transfers; init_done 4 cycles after MR0 transfer.
REQ-038 pll_locked drops during CKE_WAIT, returns 3 cycles later -> ddr_cke=0, ddr_reset_n=0 next edge; full sequence restarts with RST_HOLD.
REQ-039 reset asserted in DONE and mid-handshake of MRS1 -> all outputs at REQ-030 values next edge.
